rr_quantum_scheduler: RTL and testbench
=======================================

Name: rr_quantum_scheduler

Overview:
- Time-slice scheduler sharing one resource among N requesters in round-robin order.
- Each grant lasts until the holder releases it or a programmable quantum expires.
- The quantum is timed by an internal WIDTH-bit up-counter with wrap-around, the same counter/adder structure as the team's CounterN_COUT blocks.
- Sits in front of a shared datapath unit, e.g. a shared adder/counter, and drives its select and enable.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 4, quantum counter width; max slice length 2^WIDTH cycles
IDW, 2, width of GRANT_ID; equals clog2(N)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
REQ  input  N  per-requester request level
DONE  input  N  per-requester early-release pulse; only the current holder's bit is honoured
QUANTUM  input  WIDTH  slice length in cycles, sampled at grant; 0 means 2^WIDTH
GRANT  output  N  one-hot grant, registered
GRANT_ID  output  IDW  index of holder; 0 when idle
BUSY  output  1  high while any GRANT bit is high
EXPIRE  output  1  one-cycle pulse on the last cycle of a slice ended by quantum expiry
SLICE_CNT  output  WIDTH  cycles elapsed in the current slice, starting at 0 on the first grant cycle

Behaviour:
- Interface: one clock, CLK. Reset is RESET: synchronous, active-high. Reset state: state=IDLE, GRANT=0, GRANT_ID=0, BUSY=0, EXPIRE=0, SLICE_CNT=0, last_holder=N-1 (so requester 0 wins first), q_latched=0.
- RESET asserted mid-slice forces the reset state at the next edge; no EXPIRE is pulsed.
- FSM states:
  - IDLE: no grant. If any REQ bit is set at edge t, enter GRANTED at t+1 with the winner's GRANT bit high.
  - GRANTED: holder h owns the resource; SLICE_CNT increments by 1 each cycle, modulo 2^WIDTH.
  - GAP: exactly one cycle with all GRANT bits low between consecutive slices (turnaround). Arbitration happens on REQ sampled in GAP. If any REQ bit is set, go to GRANTED; else go to IDLE.
- Arbitration: winner = first requester with REQ set, scanning from (last_holder+1) mod N upward with wrap. last_holder updates to the winner on grant.
- Grant start: q_latched <= QUANTUM and SLICE_CNT <= 0. QUANTUM changes mid-slice have no effect.
- End-of-slice conditions, evaluated each GRANTED cycle:
  - REQ[h]=0 or DONE[h]=1: release. This cycle is the last grant cycle; EXPIRE=0.
  - Otherwise, SLICE_CNT == q_latched-1 mod 2^WIDTH: expiry. EXPIRE=1 combinationally in this, the last grant cycle.
  - q_latched=0 yields a 2^WIDTH-cycle slice: SLICE_CNT reaches all-ones and wraps.
  - Release and expiry in the same cycle: release wins; EXPIRE=0.
- After the last grant cycle at t, the next edge enters GAP, so GRANT=0 at t+1. Earliest next grant is t+2.
- After expiry, h remains eligible but ranks last in round-robin. If h is the sole requester, it is re-granted after GAP.
- DONE bits of non-holders are ignored. REQ bits may change freely; only the holder's REQ and the bits sampled at arbitration matter.
- GRANT, GRANT_ID and SLICE_CNT are registered outputs. BUSY = |GRANT. EXPIRE is a decode of registered state.
- Invariant: GRANT is one-hot or zero at all times.

Test Plan:
1. Reset, then REQ=0001, QUANTUM=3, hold → GRANT=0001 for cycles 1-3 with SLICE_CNT 0,1,2 and EXPIRE=1 in cycle 3. GAP in cycle 4. Re-grant 0001 in cycle 5.
2. REQ=1111, QUANTUM=2 → grant order 0,1,2,3,0 with one GAP cycle between slices. EXPIRE pulses once per slice. GRANT_ID follows 0,1,2,3,0.
3. REQ=0011, QUANTUM=5; DONE[0] pulsed in slice cycle 2 → requester 0 holds 2 cycles, EXPIRE=0. After GAP, GRANT=0010. DONE[1] pulsed while 0 holds has no effect.
4. QUANTUM=0, REQ=0100 → slice lasts 16 cycles; SLICE_CNT runs 0..15; EXPIRE on SLICE_CNT=15.
5. QUANTUM=4 with REQ[0] dropped in the same cycle SLICE_CNT=3 → release wins, EXPIRE=0. QUANTUM changed to 1 mid-slice → current slice is unaffected.
6. RESET asserted in slice cycle 2 of requester 2 → next cycle GRANT=0, EXPIRE=0. With REQ=1111 still held after reset release, requester 0 is granted first.

Source files
------------

// File: rtl/rr_quantum_scheduler.sv
// rr_quantum_scheduler: round-robin time-slice scheduler for one shared resource.
// One requester holds GRANT at a time. Its slice ends when it drops REQ,
// pulses DONE, or runs for its latched quantum. A one-cycle gap always
// separates consecutive slices.
module rr_quantum_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N-1:0]     REQ,
  input  logic [N-1:0]     DONE,
  input  logic [WIDTH-1:0] QUANTUM,
  output logic [N-1:0]     GRANT,
  output logic [IDW-1:0]   GRANT_ID,
  output logic             BUSY,
  output logic             EXPIRE,
  output logic [WIDTH-1:0] SLICE_CNT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANTED = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   last_holder;
  logic [WIDTH-1:0] q_latched;

  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   cand;
  logic             slice_release;
  logic             slice_expire;
  logic             slice_end;

  // Round-robin pick: first set REQ bit scanning upward from last_holder+1.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDW'((int'(last_holder) + i) % N);
      if (!win_valid && REQ[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  // End-of-slice decode; release takes priority over quantum expiry.
  always_comb begin
    slice_release = 1'b0;
    slice_expire  = 1'b0;
    if (state == S_GRANTED) begin
      slice_release = !REQ[GRANT_ID] || DONE[GRANT_ID];
      // q_latched = 0 wraps to all-ones here, giving a full 2^WIDTH slice.
      slice_expire  = !slice_release && (SLICE_CNT == q_latched - WIDTH'(1));
    end
  end

  assign slice_end = slice_release || slice_expire;
  assign EXPIRE    = slice_expire;
  assign BUSY      = |GRANT;

  // FSM, grant registers and wrap-around slice counter.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RESET) begin
      state       <= S_IDLE;
      GRANT       <= '0;
      GRANT_ID    <= '0;
      SLICE_CNT   <= '0;
      last_holder <= IDW'(N - 1);
      q_latched   <= '0;
    end else begin
      case (state)
        S_IDLE, S_GAP: begin
          if (win_valid) begin
            state       <= S_GRANTED;
            GRANT       <= {{(N-1){1'b0}}, 1'b1} << win_id;
            GRANT_ID    <= win_id;
            last_holder <= win_id;
            q_latched   <= QUANTUM;
            SLICE_CNT   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GRANTED: begin
          if (slice_end) begin
            state     <= S_GAP;
            GRANT     <= '0;
            GRANT_ID  <= '0;
            SLICE_CNT <= '0;
          end else begin
            SLICE_CNT <= SLICE_CNT + WIDTH'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          GRANT     <= '0;
          GRANT_ID  <= '0;
          SLICE_CNT <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_quantum_scheduler.sv
// Directed bench for rr_quantum_scheduler. Inputs change 1 ns after each
// rising edge; outputs are observed in the same window, away from the edge.
module tb_rr_quantum_scheduler;

  localparam int N     = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [N-1:0]     REQ;
  logic [N-1:0]     DONE;
  logic [WIDTH-1:0] QUANTUM;
  logic [N-1:0]     GRANT;
  logic [IDW-1:0]   GRANT_ID;
  logic             BUSY;
  logic             EXPIRE;
  logic [WIDTH-1:0] SLICE_CNT;

  int checks   = 0;
  int failures = 0;

  rr_quantum_scheduler #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ       (REQ),
    .DONE      (DONE),
    .QUANTUM   (QUANTUM),
    .GRANT     (GRANT),
    .GRANT_ID  (GRANT_ID),
    .BUSY      (BUSY),
    .EXPIRE    (EXPIRE),
    .SLICE_CNT (SLICE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge and settle just past it; check the one-hot invariant.
  task automatic step();
    @(posedge CLK);
    #1;
    check("onehot0", 32'($onehot0(GRANT)), 32'd1);
  endtask

  task automatic expect_state(input string tag, input logic [N-1:0] g, input int id,
                              input int cnt, input logic exp_expire);
    check({tag, ".grant"},  32'(GRANT),     32'(g));
    check({tag, ".id"},     32'(GRANT_ID),  32'(id));
    check({tag, ".busy"},   32'(BUSY),      32'(g != '0));
    check({tag, ".cnt"},    32'(SLICE_CNT), 32'(cnt));
    check({tag, ".expire"}, 32'(EXPIRE),    32'(exp_expire));
  endtask

  task automatic do_reset();
    RESET = 1'b1; REQ = '0; DONE = '0; QUANTUM = '0;
    step();
    step();
    expect_state("reset", 4'b0000, 0, 0, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; REQ = '0; DONE = '0; QUANTUM = '0;

    // 1: sole requester, quantum 3, re-granted after the gap.
    do_reset();
    REQ = 4'b0001; QUANTUM = 4'd3;
    step(); expect_state("t1.c1", 4'b0001, 0, 0, 1'b0);
    step(); expect_state("t1.c2", 4'b0001, 0, 1, 1'b0);
    step(); expect_state("t1.c3", 4'b0001, 0, 2, 1'b1);
    step(); expect_state("t1.gap", 4'b0000, 0, 0, 1'b0);
    step(); expect_state("t1.c5", 4'b0001, 0, 0, 1'b0);

    // 2: all requesting, quantum 2: order 0,1,2,3,0 with a gap between slices.
    do_reset();
    REQ = 4'b1111; QUANTUM = 4'd2;
    for (int s = 0; s < 5; s++) begin
      step(); expect_state($sformatf("t2.s%0d.a", s), 4'b0001 << (s % 4), s % 4, 0, 1'b0);
      step(); expect_state($sformatf("t2.s%0d.b", s), 4'b0001 << (s % 4), s % 4, 1, 1'b1);
      step(); expect_state($sformatf("t2.s%0d.gap", s), 4'b0000, 0, 0, 1'b0);
    end

    // 3: early release by DONE[0]; DONE[1] while 0 holds is ignored.
    do_reset();
    REQ = 4'b0011; QUANTUM = 4'd5;
    step(); DONE = 4'b0010; #1;
    expect_state("t3.c1", 4'b0001, 0, 0, 1'b0);
    step(); DONE = 4'b0001; #1;
    expect_state("t3.c2", 4'b0001, 0, 1, 1'b0);
    step(); DONE = 4'b0000;
    expect_state("t3.gap", 4'b0000, 0, 0, 1'b0);
    step(); expect_state("t3.next", 4'b0010, 1, 0, 1'b0);

    // 4: quantum 0 means a 16-cycle slice with SLICE_CNT 0..15.
    do_reset();
    REQ = 4'b0100; QUANTUM = 4'd0;
    step();
    for (int k = 0; k < 16; k++) begin
      expect_state($sformatf("t4.k%0d", k), 4'b0100, 2, k, k == 15);
      step();
    end
    expect_state("t4.gap", 4'b0000, 0, 0, 1'b0);
    step(); expect_state("t4.regrant", 4'b0100, 2, 0, 1'b0);

    // 5: release coincides with expiry; mid-slice QUANTUM change has no effect.
    do_reset();
    REQ = 4'b0001; QUANTUM = 4'd4;
    step(); QUANTUM = 4'd1; #1;
    expect_state("t5.c1", 4'b0001, 0, 0, 1'b0);
    step(); expect_state("t5.c2", 4'b0001, 0, 1, 1'b0);
    step(); expect_state("t5.c3", 4'b0001, 0, 2, 1'b0);
    step(); expect_state("t5.c4", 4'b0001, 0, 3, 1'b1);
    REQ = 4'b0000; #1;
    expect_state("t5.c4rel", 4'b0001, 0, 3, 1'b0);
    step(); expect_state("t5.gap", 4'b0000, 0, 0, 1'b0);
    step(); expect_state("t5.idle", 4'b0000, 0, 0, 1'b0);

    // 6: reset mid-slice of requester 2; requester 0 wins first afterwards.
    do_reset();
    REQ = 4'b0100; QUANTUM = 4'd8;
    step(); expect_state("t6.c1", 4'b0100, 2, 0, 1'b0);
    step(); expect_state("t6.c2", 4'b0100, 2, 1, 1'b0);
    RESET = 1'b1; REQ = 4'b1111;
    step(); expect_state("t6.rst", 4'b0000, 0, 0, 1'b0);
    RESET = 1'b0;
    step(); expect_state("t6.first", 4'b0001, 0, 0, 1'b0);
    step(); expect_state("t6.second", 4'b0001, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
